st_ctrl: RTL

- Memory-stage store controller. It is the write-side counterpart of the writeback load-extension path.
- Decodes SB/SH/SW in the M-stage instruction and checks alignment.
- Generates the word address, byte-lane enables and lane-replicated write data, then drives a req/ack handshake to data memory.
- Stalls the pipeline until the store is acknowledged or times out.

---
 rtl/st_ctrl_if.sv | 30 +++
 rtl/st_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/st_ctrl_if.sv
// Data-memory write port used by the M-stage store controller.
//
// Handshake: req/ack. The master raises mem_req with mem_addr, mem_wdata and
// mem_be valid and holds all four stable until it samples mem_ack high at a
// rising edge; that edge completes the transfer and mem_req drops the next
// cycle. The master may also withdraw mem_req after its own timeout, in which
// case the write is abandoned. mem_ack seen while mem_req is low means nothing.
interface st_ctrl_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ack
    );
endinterface

// File: rtl/st_ctrl.sv
// M-stage store controller: decodes SB/SH/SW, checks alignment, builds the
// word address, byte lanes and lane-replicated data, and holds the pipeline
// while the write waits for mem_ack (or gives up after TIMEOUT cycles).
module st_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_M,
    input  logic [31:0] AO_M,
    input  logic [31:0] RT_M,
    input  logic        valid_M,
    input  logic        flush_M,
    output logic        stall,
    output logic        ades,
    output logic        bus_err,
    output logic        state_dbg,
    st_ctrl_if.master   mem
);

    localparam logic [5:0]  OP_SB = 6'h28;
    localparam logic [5:0]  OP_SH = 6'h29;
    localparam logic [5:0]  OP_SW = 6'h2b;
    localparam logic [15:0] LAST  = 16'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [5:0]  op;
    logic        is_store;
    logic        aligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        start;
    logic        misalign;
    logic        expire;
    logic [15:0] cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        unused_ir;

    assign op        = IR_M[31:26];
    assign unused_ir = ^IR_M[25:0];
    assign is_store  = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    assign start     = valid_M && !flush_M && is_store && aligned && (state == IDLE);
    assign misalign  = valid_M && !flush_M && is_store && !aligned && (state == IDLE);
    assign expire    = (cnt == LAST);
    assign state_dbg = state;

    // Address and data leave through registers so they stay put for the whole request.
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // Store decode: alignment, little-endian lane enables, replicated write data.
    always_comb begin
        aligned = 1'b0;
        be_d    = 4'b0000;
        wdata_d = RT_M;
        case (op)
            OP_SB: begin
                aligned = 1'b1;
                be_d    = 4'b0001 << AO_M[1:0];
                wdata_d = {4{RT_M[7:0]}};
            end
            OP_SH: begin
                aligned = !AO_M[0];
                be_d    = AO_M[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{RT_M[15:0]}};
            end
            OP_SW: begin
                aligned = (AO_M[1:0] == 2'b00);
                be_d    = 4'b1111;
            end
            default: ;
        endcase
    end

    // Next state and handshake outputs; a timeout releases the stall in its last cycle.
    always_comb begin
        state_nx     = state;
        stall        = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_be   = 4'b0000;
        case (state)
            IDLE: begin
                stall = start;
                if (start) state_nx = BUSY;
            end
            BUSY: begin
                mem.mem_req = 1'b1;
                mem.mem_be  = be_q;
                stall       = !mem.mem_ack && !expire;
                if (mem.mem_ack || expire) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Latch the store at start; count waiting cycles (saturating) while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'b0000;
            cnt     <= 16'h0;
        end else if (start) begin
            addr_q  <= {AO_M[31:2], 2'b00};
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt     <= 16'h0;
        end else if ((state == BUSY) && !mem.mem_ack && !expire && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'h1;
        end
    end

    // One-cycle exception pulses, registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            ades    <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            ades    <= misalign;
            bus_err <= (state == BUSY) && !mem.mem_ack && expire;
        end
    end

endmodule
